// File: rtl/maxpool2_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : maxpool2_reader_if
//  Description : Bundles the connection between the conv2 stage, the max-pool
//                reader and the dense-stage consumer: the start/done handshake,
//                the conv2 feature maps read by the pooling reader, and the
//                pooled result maps.
//                Optional streaming outputs are present when MAXPOOL2_STREAM_EN
//                is defined.
//  Modports    : master - drives start/in_maps, observes done/pooled/stream
//                slave  - the pooling reader itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface maxpool2_reader_if #(
    parameter int CHANNELS = 32,
    parameter int IN_DIM   = 14,
    parameter int DATA_W   = 32
);
    localparam int OUT_DIM = IN_DIM / 2;
    localparam int N_OUT   = CHANNELS * OUT_DIM * OUT_DIM;
    localparam int IDX_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic                     start;
    logic                     done;
    logic signed [DATA_W-1:0] in_maps     [CHANNELS][IN_DIM][IN_DIM];
    logic signed [DATA_W-1:0] pooled_maps [CHANNELS][OUT_DIM][OUT_DIM];

`ifdef MAXPOOL2_STREAM_EN
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]         out_idx;

    modport master (
        output start, in_maps,
        input  done, pooled_maps, out_valid, out_data, out_idx
    );
    modport slave (
        input  start, in_maps,
        output done, pooled_maps, out_valid, out_data, out_idx
    );
`else
    modport master (
        output start, in_maps,
        input  done, pooled_maps
    );
    modport slave (
        input  start, in_maps,
        output done, pooled_maps
    );
`endif
endinterface
`default_nettype wire

// File: rtl/maxpool2_reader.sv
`default_nettype none
// ============================================================================
//  Module      : maxpool2_reader
//  Description : Sequential 2x2 stride-2 max-pooling reader. After a start
//                request it walks the CHANNELS x IN_DIM x IN_DIM conv2 maps one
//                element per cycle (4 READ cycles + 1 WRITE cycle per output)
//                and stores CHANNELS x OUT_DIM x OUT_DIM signed maxima.
//  Ports       : clk   - system clock
//                reset - synchronous, active-high
//                bus   - maxpool2_reader_if.slave: start (level), done (held
//                        until next accepted start), in_maps, pooled_maps and,
//                        with MAXPOOL2_STREAM_EN, out_valid/out_data/out_idx
//  Config      : define MAXPOOL2_STREAM_EN to add a per-output result stream
//  Revision    : 1.0 - initial release
// ============================================================================
module maxpool2_reader #(
    parameter int CHANNELS = 32,
    parameter int IN_DIM   = 14,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    maxpool2_reader_if.slave  bus
);
    localparam int OUT_DIM = IN_DIM / 2;
    localparam int F_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int O_W     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    localparam logic [F_W-1:0] c_last_f = F_W'(CHANNELS - 1);
    localparam logic [O_W-1:0] c_last_o = O_W'(OUT_DIM - 1);

    generate
        if ((IN_DIM % 2) != 0) begin : g_dim_check
            $error("maxpool2_reader: IN_DIM must be even");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_READ       = 3'd1,
        S_WRITE      = 3'd2,
        S_DONE       = 3'd3,
        S_WAIT_START = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_done;
    logic [F_W-1:0]           r_f;
    logic [O_W-1:0]           r_oi;
    logic [O_W-1:0]           r_oj;
    logic [1:0]               r_k;
    logic signed [DATA_W-1:0] r_acc;
    logic signed [DATA_W-1:0] r_pool [CHANNELS][OUT_DIM][OUT_DIM];

    logic signed [DATA_W-1:0] w_elem;
    logic                     w_last_oj;
    logic                     w_last_oi;
    logic                     w_last_out;

    // Window element k: k[1] selects the row, k[0] the column inside the 2x2
    // window, so {o, k-bit} is exactly 2*o + k-bit.
    assign w_elem     = bus.in_maps[r_f][{r_oi, r_k[1]}][{r_oj, r_k[0]}];
    assign w_last_oj  = (r_oj == c_last_o);
    assign w_last_oi  = (r_oi == c_last_o);
    assign w_last_out = w_last_oj && w_last_oi && (r_f == c_last_f);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:       if (bus.start) w_state_nxt = S_READ;
            S_READ:       if (r_k == 2'd3) w_state_nxt = S_WRITE;
            S_WRITE:      w_state_nxt = w_last_out ? S_DONE : S_READ;
            S_DONE:       w_state_nxt = S_WAIT_START;
            // start must be seen low before another pass is accepted
            S_WAIT_START: if (!bus.start) w_state_nxt = S_IDLE;
            default:      w_state_nxt = S_IDLE;
        endcase
    end

`ifdef MAXPOOL2_STREAM_EN
    localparam int N_OUT = CHANNELS * OUT_DIM * OUT_DIM;
    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic                     r_out_valid;
    logic signed [DATA_W-1:0] r_out_data;
    logic [IDX_W-1:0]         r_out_idx;
    // Raster order makes the linear index a simple running count.
    logic [IDX_W-1:0]         r_lin;

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_idx   = r_out_idx;
`endif

    // ------------------------------------------------------------------
    // Datapath: counters, running maximum, result storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
            r_f    <= '0;
            r_oi   <= '0;
            r_oj   <= '0;
            r_k    <= '0;
            r_acc  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                for (int i = 0; i < OUT_DIM; i++) begin
                    for (int j = 0; j < OUT_DIM; j++) begin
                        r_pool[c][i][j] <= '0;
                    end
                end
            end
`ifdef MAXPOOL2_STREAM_EN
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_lin       <= '0;
`endif
        end else begin
`ifdef MAXPOOL2_STREAM_EN
            r_out_valid <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_done <= 1'b0;
                        r_f    <= '0;
                        r_oi   <= '0;
                        r_oj   <= '0;
                        r_k    <= '0;
`ifdef MAXPOOL2_STREAM_EN
                        r_lin  <= '0;
`endif
                    end
                end
                S_READ: begin
                    if (r_k == 2'd0) begin
                        r_acc <= w_elem;
                    end else if (w_elem > r_acc) begin
                        r_acc <= w_elem;
                    end
                    // 2-bit counter wraps 3 -> 0 on the last READ
                    r_k <= r_k + 2'd1;
                end
                S_WRITE: begin
                    r_pool[r_f][r_oi][r_oj] <= r_acc;
                    if (w_last_oj) begin
                        r_oj <= '0;
                        if (w_last_oi) begin
                            r_oi <= '0;
                            r_f  <= (r_f == c_last_f) ? '0 : r_f + 1'b1;
                        end else begin
                            r_oi <= r_oi + 1'b1;
                        end
                    end else begin
                        r_oj <= r_oj + 1'b1;
                    end
`ifdef MAXPOOL2_STREAM_EN
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_acc;
                    r_out_idx   <= r_lin;
                    r_lin       <= r_lin + 1'b1;
`endif
                end
                S_DONE: begin
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.done        = r_done;
    assign bus.pooled_maps = r_pool;

endmodule
`default_nettype wire

// File: tb/tb_maxpool2_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maxpool2_reader
//  Description : Self-checking bench for maxpool2_reader. A small instance
//                (2x4x4 -> 2x2x2) is checked every cycle against a
//                behavioural model; a default-size instance (32x14x14) is run
//                once on random data. Stream outputs are checked when
//                MAXPOOL2_STREAM_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_maxpool2_reader;
    localparam int SC = 2;
    localparam int SI = 4;
    localparam int SO = SI / 2;
    localparam int SN = SC * SO * SO;
    localparam int BC = 32;
    localparam int BI = 14;
    localparam int BO = BI / 2;
    localparam int BN = BC * BO * BO;
    localparam int W  = 32;
    localparam logic signed [W-1:0] MINV = 32'sh8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s = 1'b1;
    logic rst_b = 1'b1;
    bit   cmp_en = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    maxpool2_reader_if #(.CHANNELS(SC), .IN_DIM(SI), .DATA_W(W)) s_if ();
    maxpool2_reader_if #(.CHANNELS(BC), .IN_DIM(BI), .DATA_W(W)) b_if ();

    maxpool2_reader #(.CHANNELS(SC), .IN_DIM(SI), .DATA_W(W)) u_small (
        .clk   (clk),
        .reset (rst_s),
        .bus   (s_if.slave)
    );

    maxpool2_reader #(.CHANNELS(BC), .IN_DIM(BI), .DATA_W(W)) u_big (
        .clk   (clk),
        .reset (rst_b),
        .bus   (b_if.slave)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Max of a 2x2 window straight from the definition.
    function automatic logic signed [W-1:0] pool_s(input int j);
        int f, oi, oj;
        logic signed [W-1:0] best;
        f  = j / (SO * SO);
        oi = (j / SO) % SO;
        oj = j % SO;
        best = s_if.in_maps[f][2*oi][2*oj];
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                if (s_if.in_maps[f][2*oi+a][2*oj+b] > best)
                    best = s_if.in_maps[f][2*oi+a][2*oj+b];
        return best;
    endfunction

    function automatic logic signed [W-1:0] pool_b(input int f, input int oi, input int oj);
        logic signed [W-1:0] best;
        best = b_if.in_maps[f][2*oi][2*oj];
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                if (b_if.in_maps[f][2*oi+a][2*oj+b] > best)
                    best = b_if.in_maps[f][2*oi+a][2*oj+b];
        return best;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model of the small instance: a pass accepted at edge E0
    // finalises output j at E0+5(j+1) and raises done at E0+5N+1; a new
    // pass needs start seen low after completion.
    // ------------------------------------------------------------------
    bit                  m_busy  = 1'b0;
    bit                  m_armed = 1'b1;
    bit                  m_done  = 1'b0;
    int                  m_cnt   = 0;
    logic signed [W-1:0] m_cur [SN];
    bit                  m_ov    = 1'b0;
    logic signed [W-1:0] m_od    = '0;
    int                  m_oidx  = 0;

    initial begin : model
        for (int j = 0; j < SN; j++) m_cur[j] = '0;
        forever begin
            @(posedge clk);
            m_ov = 1'b0;
            if (rst_s) begin
                m_busy = 1'b0; m_armed = 1'b1; m_done = 1'b0; m_cnt = 0;
                m_od = '0; m_oidx = 0;
                for (int j = 0; j < SN; j++) m_cur[j] = '0;
            end else if (m_busy) begin
                m_cnt++;
                if ((m_cnt % 5) == 0 && (m_cnt / 5) <= SN) begin
                    m_cur[m_cnt/5 - 1] = pool_s(m_cnt/5 - 1);
                    m_ov   = 1'b1;
                    m_od   = m_cur[m_cnt/5 - 1];
                    m_oidx = m_cnt/5 - 1;
                end
                if (m_cnt == 5*SN + 1) begin
                    m_busy = 1'b0; m_done = 1'b1; m_armed = 1'b0;
                end
            end else if (s_if.start && m_armed) begin
                m_busy = 1'b1; m_cnt = 0; m_done = 1'b0;
            end else if (!s_if.start) begin
                m_armed = 1'b1;
            end
        end
    end

    logic signed [W-1:0] q_stream [$];

    initial begin : compare
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("done", s_if.done, m_done);
                for (int j = 0; j < SN; j++)
                    chk($sformatf("pooled[%0d]", j),
                        s_if.pooled_maps[j/(SO*SO)][(j/SO)%SO][j%SO], m_cur[j]);
`ifdef MAXPOOL2_STREAM_EN
                chk("out_valid", s_if.out_valid, m_ov);
                chk("out_data", s_if.out_data, m_od);
                chk("out_idx", s_if.out_idx, m_oidx);
                if (s_if.out_valid) q_stream.push_back(s_if.out_data);
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic fill_random_s();
        for (int c = 0; c < SC; c++)
            for (int r = 0; r < SI; r++)
                for (int q = 0; q < SI; q++)
                    s_if.in_maps[c][r][q] = $urandom;
    endtask

    // Returns at #1 after the edge where start is sampled high.
    task automatic pulse_start_s();
        @(posedge clk); #1 s_if.start = 1'b1;
        @(posedge clk); #1 s_if.start = 1'b0;
    endtask

    // Counts edges until done is seen, starting from n0.
    task automatic wait_done_s(input int n0, output int n);
        n = n0;
        while (!s_if.done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    int lat;
    int ramp_exp [SN] = '{5, 7, 13, 15, 21, 23, 29, 31};

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        s_if.start = 1'b0;
        b_if.start = 1'b0;
        for (int c = 0; c < SC; c++)
            for (int r = 0; r < SI; r++)
                for (int q = 0; q < SI; q++)
                    s_if.in_maps[c][r][q] = '0;
        for (int c = 0; c < BC; c++)
            for (int r = 0; r < BI; r++)
                for (int q = 0; q < BI; q++)
                    b_if.in_maps[c][r][q] = $urandom;

        repeat (2) @(posedge clk);
        #1 cmp_en = 1'b1;
        @(posedge clk); #1;
        chk("reset_done", s_if.done, 0);
        chk("reset_pool", s_if.pooled_maps[1][1][1], 0);
        rst_s = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);

        // Ramp
        for (int c = 0; c < SC; c++)
            for (int r = 0; r < SI; r++)
                for (int q = 0; q < SI; q++)
                    s_if.in_maps[c][r][q] = 16*c + 4*r + q;
        q_stream.delete();
        pulse_start_s();
        wait_done_s(0, lat);
        chk("ramp_latency", lat, 41);
        for (int j = 0; j < SN; j++)
            chk($sformatf("ramp_pool[%0d]", j),
                s_if.pooled_maps[j/4][(j/2)%2][j%2], ramp_exp[j]);
`ifdef MAXPOOL2_STREAM_EN
        chk("stream_count", q_stream.size(), SN);
        for (int j = 0; j < SN && j < q_stream.size(); j++)
            chk($sformatf("stream_data[%0d]", j), q_stream[j], ramp_exp[j]);
`endif
        @(posedge clk); #1;

        // Signed windows
        fill_random_s();
        s_if.in_maps[0][0][0] = -32'sd7;  s_if.in_maps[0][0][1] = -32'sd3;
        s_if.in_maps[0][1][0] = -32'sd9;  s_if.in_maps[0][1][1] = -32'sd5;
        s_if.in_maps[0][0][2] = -32'sd1;  s_if.in_maps[0][0][3] = 32'sd0;
        s_if.in_maps[0][1][2] = -32'sd2;  s_if.in_maps[0][1][3] = -32'sd1;
        for (int r = 0; r < 2; r++)
            for (int q = 0; q < 2; q++)
                s_if.in_maps[1][r][q] = MINV;
        pulse_start_s();
        wait_done_s(0, lat);
        chk("signed_latency", lat, 41);
        chk("signed_neg", s_if.pooled_maps[0][0][0], -3);
        chk("signed_zero", s_if.pooled_maps[0][0][1], 0);
        chk("signed_min", s_if.pooled_maps[1][0][0], MINV);

        // Handshake: start held through completion
        fill_random_s();
        @(posedge clk); #1 s_if.start = 1'b1;
        @(posedge clk); #1;
        wait_done_s(0, lat);
        chk("hold_latency", lat, 41);
        repeat (30) @(posedge clk);
        #1 chk("hold_done_stays", s_if.done, 1);
        s_if.start = 1'b0;
        repeat (2) @(posedge clk);
        fill_random_s();
        #1 s_if.start = 1'b1;
        @(posedge clk); #1 s_if.start = 1'b0;
        chk("retrigger_done_clear", s_if.done, 0);
        repeat (9) @(posedge clk);
        #1 s_if.start = 1'b1;
        @(posedge clk); #1 s_if.start = 1'b0;
        wait_done_s(10, lat);
        chk("midpass_latency", lat, 41);
        repeat (20) @(posedge clk);
        #1;

        // Reset mid-pass
        fill_random_s();
        pulse_start_s();
        repeat (16) @(posedge clk);
        #1 rst_s = 1'b1;
        @(posedge clk); #1 rst_s = 1'b0;
        chk("rst_done", s_if.done, 0);
        for (int j = 0; j < SN; j++)
            chk($sformatf("rst_pool[%0d]", j), s_if.pooled_maps[j/4][(j/2)%2][j%2], 0);
        pulse_start_s();
        wait_done_s(0, lat);
        chk("after_rst_latency", lat, 41);

        // Default size, random signed data
        @(posedge clk); #1 b_if.start = 1'b1;
        @(posedge clk); #1 b_if.start = 1'b0;
        chk("big_done_cleared", b_if.done, 0);
        lat = 0;
        while (!b_if.done && lat < 9000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("big_latency", lat, 5*BN + 1);
        for (int f = 0; f < BC; f++)
            for (int i = 0; i < BO; i++)
                for (int j = 0; j < BO; j++)
                    chk($sformatf("big_pool[%0d][%0d][%0d]", f, i, j),
                        b_if.pooled_maps[f][i][j], pool_b(f, i, j));

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
